vga_sync_gen: RTL and testbench

//  Generates 640x480@60 Hz VGA timing from CLK100MHZ using a divide-by-4 pixel enable.

---
 rtl/vga_sync_gen_pkg.sv | 46 ++++
 rtl/vga_sync_gen_sync_delay_line.sv | 42 ++++
 rtl/vga_sync_gen.sv | 119 +++++++++++
 tb/tb_vga_sync_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen_pkg
//  Description : Shared 640x480@60 Hz VGA timing constants, the bundle of
//                delayed sync/video bits and a sync polarity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_sync_gen_pkg;

  // Horizontal timing in pixels
  localparam int c_h_display = 640;
  localparam int c_h_front   = 16;
  localparam int c_h_sync    = 96;
  localparam int c_h_back    = 48;
  localparam int c_h_total   = c_h_display + c_h_front + c_h_sync + c_h_back;

  // Vertical timing in lines
  localparam int c_v_display = 480;
  localparam int c_v_front   = 10;
  localparam int c_v_sync    = 2;
  localparam int c_v_back    = 33;
  localparam int c_v_total   = c_v_display + c_v_front + c_v_sync + c_v_back;

  // Sync pulse windows (inclusive bounds)
  localparam int c_hs_start  = c_h_display + c_h_front;
  localparam int c_hs_end    = c_h_display + c_h_front + c_h_sync - 1;
  localparam int c_vs_start  = c_v_display + c_v_front;
  localparam int c_vs_end    = c_v_display + c_v_front + c_v_sync - 1;

  // System clocks per pixel
  localparam int c_clk_div   = 4;

  // Bits carried through the alignment delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic vid;
  } sync_bits_t;

  // Drive a sync line to its active level or to the opposite level
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_sync_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen_sync_delay_line
//  Description : Enable-gated shift register that delays the sync/video bits
//                so they line up with the renderer's pipelined rgb output.
//                DEPTH 0 still keeps one stage so the outputs stay registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen_sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  localparam int c_stages = (DEPTH < 1) ? 1 : DEPTH;

  logic [WIDTH-1:0] r_stage [c_stages];

  // Shift one stage per enable; every stage resets to the idle pattern
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < c_stages; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < c_stages; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[c_stages-1];

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : VGA timing generator. Divides the system clock into a pixel
//                enable, runs the x/y raster counters, decodes sync/video and
//                delays them to match the renderer. Also emits frame and
//                vblank strobes for the physics update.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int   CLK_DIV   = c_clk_div,
  parameter int   H_DISPLAY = c_h_display,
  parameter int   H_FRONT   = c_h_front,
  parameter int   H_SYNC    = c_h_sync,
  parameter int   H_BACK    = c_h_back,
  parameter int   V_DISPLAY = c_v_display,
  parameter int   V_FRONT   = c_v_front,
  parameter int   V_SYNC    = c_v_sync,
  parameter int   V_BACK    = c_v_back,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   PIPE_DLY  = 2
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       vblank_start,
  output logic       video_on,
  output logic       VGA_HS,
  output logic       VGA_VS
);

  localparam int c_div_w   = $clog2(CLK_DIV);
  localparam int c_h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_pre  = c_div_w'(CLK_DIV - 2);

  localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_vis    = 10'(H_DISPLAY);
  localparam logic [9:0] c_v_vis    = 10'(V_DISPLAY);
  localparam logic [9:0] c_hs_first = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] c_hs_final = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] c_vs_first = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] c_vs_final = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Idle pattern: syncs inactive, video blanked
  localparam logic [2:0] c_idle = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [c_div_w-1:0] r_div;
  logic               r_pix_tick;
  logic [9:0]         r_x;
  logic [9:0]         r_y;
  sync_bits_t         w_raw;
  sync_bits_t         w_dly;

  // Clock divider; the tick is registered so it is high exactly while div is at its last count
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_div      <= '0;
      r_pix_tick <= 1'b0;
    end else begin
      r_div      <= (r_div == c_div_last) ? '0 : r_div + 1'b1;
      r_pix_tick <= (r_div == c_div_pre);
    end
  end

  // Raster counters advance on the edge that closes a tick cycle
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_pix_tick) begin
      if (r_x == c_h_last) begin
        r_x <= '0;
        r_y <= (r_y == c_v_last) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Raw sync/video decode of the pixel currently being emitted
  always_comb begin
    w_raw     = c_idle;
    w_raw.hs  = sync_level((r_x >= c_hs_first) && (r_x <= c_hs_final), SYNC_POL);
    w_raw.vs  = sync_level((r_y >= c_vs_first) && (r_y <= c_vs_final), SYNC_POL);
    w_raw.vid = (r_x < c_h_vis) && (r_y < c_v_vis);
  end

  vga_sync_gen_sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DLY),
    .RESET_VAL (c_idle)
  ) u_delay (
    .i_clk   (CLK100MHZ),
    .i_rst_n (CPU_RESETN),
    .i_en    (r_pix_tick),
    .i_d     (w_raw),
    .o_q     (w_dly)
  );

  assign pix_tick     = r_pix_tick;
  assign x            = r_x;
  assign y            = r_y;
  assign frame_start  = r_pix_tick && (r_x == '0) && (r_y == '0);
  assign vblank_start = r_pix_tick && (r_x == '0) && (r_y == c_v_vis);
  assign video_on     = w_dly.vid;
  assign VGA_HS       = w_dly.hs;
  assign VGA_VS       = w_dly.vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Self-checking bench for vga_sync_gen using a shrunk raster so
//                several whole frames fit in a short run. Expected values come
//                from plain arithmetic on the clock count since reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  localparam int   CLK_DIV = 4;
  localparam int   HD = 8, HF = 2, HSY = 3, HB = 2;
  localparam int   VD = 6, VF = 1, VSY = 2, VB = 2;
  localparam int   HT = HD + HF + HSY + HB;
  localparam int   VT = VD + VF + VSY + VB;
  localparam int   PIPE = 2;
  localparam logic POL = 1'b0;
  localparam int   FRAME_CLKS = HT * VT * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_tick, frame_start, vblank_start, video_on, vga_hs, vga_vs;
  logic [9:0] x, y;

  int k = 0;
  int total = 0;
  int bad = 0;

  vga_sync_gen #(
    .CLK_DIV(CLK_DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .SYNC_POL(POL), .PIPE_DLY(PIPE)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .pix_tick(pix_tick), .x(x), .y(y),
    .frame_start(frame_start), .vblank_start(vblank_start), .video_on(video_on),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs)
  );

  always #5 clk = ~clk;

  // clocks elapsed since reset release (0 during the first cycle after release)
  always @(posedge clk) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // ---------------- reference model ----------------
  function automatic int pix_of(int kk);
    return kk / CLK_DIV;
  endfunction
  function automatic logic m_tick(int kk);
    return (kk % CLK_DIV) == CLK_DIV - 1;
  endfunction
  function automatic int m_x(int kk);
    return pix_of(kk) % HT;
  endfunction
  function automatic int m_y(int kk);
    return (pix_of(kk) / HT) % VT;
  endfunction
  // {hs, vs, vid} shown while pixel p is emitted describe pixel p-PIPE
  function automatic logic [2:0] m_out(int kk);
    int q;
    int qx;
    int qy;
    logic hs;
    logic vs;
    logic vid;
    q = pix_of(kk) - PIPE;
    if (q < 0) return {~POL, ~POL, 1'b0};
    qx  = q % HT;
    qy  = (q / HT) % VT;
    hs  = (qx >= HD + HF && qx < HD + HF + HSY) ? POL : ~POL;
    vs  = (qy >= VD + VF && qy < VD + VF + VSY) ? POL : ~POL;
    vid = (qx < HD) && (qy < VD);
    return {hs, vs, vid};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (pix_tick !== 1'b0)     begin bad++; $display("FAIL reset_tick got=%b exp=0", pix_tick); end
    total++; if (x !== 10'd0)           begin bad++; $display("FAIL reset_x got=%0d exp=0", x); end
    total++; if (y !== 10'd0)           begin bad++; $display("FAIL reset_y got=%0d exp=0", y); end
    total++; if (frame_start !== 1'b0)  begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    total++; if (vblank_start !== 1'b0) begin bad++; $display("FAIL reset_vb got=%b exp=0", vblank_start); end
    total++; if (video_on !== 1'b0)     begin bad++; $display("FAIL reset_vid got=%b exp=0", video_on); end
    total++; if (vga_hs !== ~POL)       begin bad++; $display("FAIL reset_hs got=%b exp=%b", vga_hs, ~POL); end
    total++; if (vga_vs !== ~POL)       begin bad++; $display("FAIL reset_vs got=%b exp=%b", vga_vs, ~POL); end
  endtask

  // release at a falling edge and check the first few tick periods
  task automatic test_first_tick(string tag);
    int first;
    logic exp_fs;
    first = -1;
    rst_n = 1'b1;
    for (int c = 0; c < 4 * CLK_DIV; c++) begin
      if (c != 0) @(negedge clk);
      if (pix_tick === 1'b1 && first < 0) first = c;
      exp_fs = m_tick(k) && m_x(k) == 0 && m_y(k) == 0;
      total++; if (pix_tick !== m_tick(k)) begin bad++; $display("FAIL %s_tick c=%0d got=%b exp=%b", tag, c, pix_tick, m_tick(k)); end
      total++; if (frame_start !== exp_fs) begin bad++; $display("FAIL %s_fs c=%0d got=%b exp=%b", tag, c, frame_start, exp_fs); end
      total++; if (x !== 10'(m_x(k)) || y !== 10'(m_y(k))) begin bad++; $display("FAIL %s_xy c=%0d got=%0d,%0d exp=%0d,%0d", tag, c, x, y, m_x(k), m_y(k)); end
    end
    total++; if (first != CLK_DIV - 1) begin bad++; $display("FAIL %s_first_tick got=%0d exp=%0d", tag, first, CLK_DIV - 1); end
  endtask

  // raster counters and line period
  task automatic test_counters(int ncyc);
    int last_wrap;
    int prev_x;
    last_wrap = -1;
    prev_x = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      total++; if (x !== 10'(m_x(k))) begin bad++; $display("FAIL cnt_x k=%0d got=%0d exp=%0d", k, x, m_x(k)); end
      total++; if (y !== 10'(m_y(k))) begin bad++; $display("FAIL cnt_y k=%0d got=%0d exp=%0d", k, y, m_y(k)); end
      if (prev_x == HT - 1 && x == 10'd0) begin
        if (last_wrap >= 0) begin
          total++; if (k - last_wrap != HT * CLK_DIV) begin bad++; $display("FAIL line_period got=%0d exp=%0d", k - last_wrap, HT * CLK_DIV); end
        end
        last_wrap = k;
      end
      prev_x = int'(x);
    end
  endtask

  // delayed sync/video alignment, hsync width, video pixel count per frame
  task automatic test_sync(int ncyc);
    logic [2:0] e;
    int run;
    int vcnt;
    run = -1;
    vcnt = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      e = m_out(k);
      total++; if ({vga_hs, vga_vs, video_on} !== e) begin bad++; $display("FAIL sync k=%0d got=%b exp=%b", k, {vga_hs, vga_vs, video_on}, e); end
      if (vga_hs === POL) begin
        if (run >= 0) run++;
      end else begin
        if (run > 0) begin
          total++; if (run != HSY * CLK_DIV) begin bad++; $display("FAIL hs_width got=%0d exp=%0d", run, HSY * CLK_DIV); end
        end
        run = 0;
      end
      if (frame_start === 1'b1) begin
        if (vcnt >= 0) begin
          total++; if (vcnt != HD * VD) begin bad++; $display("FAIL vid_count got=%0d exp=%0d", vcnt, HD * VD); end
        end
        vcnt = 0;
      end
      if (vcnt >= 0 && pix_tick === 1'b1 && video_on === 1'b1) vcnt++;
    end
  endtask

  // frame and vblank strobes
  task automatic test_strobes(int ncyc);
    logic exp_fs;
    logic exp_vb;
    int last_fs;
    int vb;
    last_fs = -1;
    vb = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      exp_fs = m_tick(k) && m_x(k) == 0 && m_y(k) == 0;
      exp_vb = m_tick(k) && m_x(k) == 0 && m_y(k) == VD;
      total++; if (frame_start !== exp_fs)  begin bad++; $display("FAIL strobe_fs k=%0d got=%b exp=%b", k, frame_start, exp_fs); end
      total++; if (vblank_start !== exp_vb) begin bad++; $display("FAIL strobe_vb k=%0d got=%b exp=%b", k, vblank_start, exp_vb); end
      if (vblank_start === 1'b1) vb++;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          total++; if (k - last_fs != FRAME_CLKS) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", k - last_fs, FRAME_CLKS); end
          total++; if (vb != 1) begin bad++; $display("FAIL vb_per_frame got=%0d exp=1", vb); end
        end
        last_fs = k;
        vb = 0;
      end
    end
  endtask

  // asynchronous reset at a random raster position
  task automatic test_mid_reset();
    repeat ($urandom_range(40, 2 * FRAME_CLKS)) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (x !== 10'd0 || y !== 10'd0) begin bad++; $display("FAIL mid_rst_xy got=%0d,%0d exp=0,0", x, y); end
    total++; if (vga_hs !== ~POL || vga_vs !== ~POL) begin bad++; $display("FAIL mid_rst_sync got=%b%b exp=%b%b", vga_hs, vga_vs, ~POL, ~POL); end
    total++; if (video_on !== 1'b0 || pix_tick !== 1'b0) begin bad++; $display("FAIL mid_rst_vid_tick got=%b%b exp=00", video_on, pix_tick); end
    repeat (2) @(negedge clk);
    test_first_tick("rerel");
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_first_tick("rel");
    test_counters(FRAME_CLKS + $urandom_range(100, FRAME_CLKS));
    test_sync(2 * FRAME_CLKS + $urandom_range(0, 200));
    test_strobes(2 * FRAME_CLKS + $urandom_range(0, 200));
    repeat (3) begin
      test_mid_reset();
      test_sync($urandom_range(100, 2 * FRAME_CLKS));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
